riscv_fetch_buffer: RTL and testbench

- Instruction-fetch front end of the pipelined RISC-V core; sits directly upstream of the IF/ID pipeline register and feeds decode.
- Generates sequential fetch PCs and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a small FIFO, and flushes or discards in-flight work on a branch/jump redirect from EX.

---
 rtl/riscv_fetch_buffer.sv | 143 ++++++++++++++
 tb/tb_riscv_fetch_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer
//   Instruction-fetch front end. Issues sequential, word-aligned fetch
//   requests to an in-order, variable-latency instruction memory. Returned
//   instructions are queued with their PCs in a DEPTH-entry FIFO that feeds
//   the IF/ID register. A redirect from EX flushes the FIFO, marks every
//   in-flight request as stale and restarts fetch at the new PC.
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   imem_req_valid_o/ready_i   fetch request handshake
//   imem_req_addr_o            fetch address (word aligned)
//   imem_resp_valid_i/data_i   in-order instruction response
//   redirect_i, redirect_pc_i  taken branch/jump from EX, new fetch PC
//   id_valid_o/ready_i         FIFO head handshake toward decode
//   id_instr_o, id_pc_o        FIFO head contents (0 when empty)
//   count_o                    FIFO occupancy
module riscv_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid_o,
    input  logic                     imem_req_ready_i,
    output logic [31:0]              imem_req_addr_o,
    input  logic                     imem_resp_valid_i,
    input  logic [31:0]              imem_resp_data_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [31:0]              id_instr_o,
    output logic [31:0]              id_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_keep;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;
    logic          unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Every accepted request reserves a FIFO slot (live) or is still owed a
    // response that will be thrown away (drop); both hold a credit.
    assign credits_used = {1'b0, count_q} + {1'b0, live_q} + {1'b0, drop_q};

    assign imem_req_valid_o = !reset && !redirect_i && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Stale responses are consumed first; a response with nothing
    // outstanding is a protocol error and is ignored.
    assign resp_drop = imem_resp_valid_i && (drop_q != '0);
    assign resp_keep = imem_resp_valid_i && (drop_q == '0) && (live_q != '0);

    assign id_valid_o = !reset && (count_q != '0);
    assign id_instr_o = id_valid_o ? instr_mem_q[rptr_q] : 32'h0;
    assign id_pc_o    = id_valid_o ? pc_mem_q[rptr_q]    : 32'h0;
    assign count_o    = reset ? '0 : count_q;

    // A redirect flushes the FIFO, so its push/pop are suppressed.
    assign push = resp_keep && !redirect_i;
    assign pop  = id_valid_o && id_ready_i && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            live_d     = '0;
            // All live requests become stale; a response arriving now is
            // one of them (or a dropped one) and is consumed here.
            drop_d     = drop_q + live_q
                       - CW'(imem_resp_valid_i && ((drop_q != '0) || (live_q != '0)));
            count_d    = '0;
            rptr_d     = '0;
            wptr_d     = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            live_d  = live_q + CW'(req_fire) - CW'(resp_keep);
            drop_d  = drop_q - CW'(resp_drop);
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wptr_d    = wptr_q + AW'(1);
            end
            if (pop) rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wptr_q] <= imem_resp_data_i;
            pc_mem_q[wptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
module tb_riscv_fetch_buffer;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    riscv_fetch_buffer #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .id_valid_o        (id_valid_o),
        .id_ready_i        (id_ready_i),
        .id_instr_o        (id_instr_o),
        .id_pc_o           (id_pc_o),
        .count_o           (count_o)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;   // memory pipe
    typedef struct { logic [31:0] addr; bit keep; } out_t;   // outstanding fetch
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mreq_t       memq[$];
    out_t        outq[$];
    ent_t        fifoq[$];
    logic [31:0] m_fpc = RST_PC;
    logic [31:0] dut_hs[$];    // addresses of observed request handshakes
    logic [31:0] dut_pops[$];  // PCs of observed pops

    int total = 0, bad = 0, cyc = 0;
    int rdy_pct = 100, idr_pct = 100, lat_min = 1, lat_max = 1;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkq(input string tag, input logic [31:0] q[$], input int idx,
                        input logic [31:0] exp);
        chk(tag, (idx < q.size()) ? q[idx] : 32'hxxxx_xxxx, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against the model at the
    // falling edge, advance the model, then step past the rising edge.
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
        bit          exp_rv, fire, resp, rdy, idr, exp_iv;
        logic [31:0] rdata;
        out_t        o;
        o = '{32'h0, 1'b0};
        rdy  = ($urandom_range(99) < rdy_pct);
        idr  = ($urandom_range(99) < idr_pct);
        resp = !rst && (memq.size() > 0) && (memq[0].due <= cyc);
        rdata = resp ? memdata(memq[0].addr) : $urandom();
        reset             = rst;
        redirect_i        = redir;
        redirect_pc_i     = rpc;
        imem_req_ready_i  = rdy;
        id_ready_i        = idr;
        imem_resp_valid_i = resp;
        imem_resp_data_i  = rdata;
        @(negedge clk);
        exp_rv = !rst && !redir && ((fifoq.size() + outq.size()) < DEPTH);
        exp_iv = !rst && (fifoq.size() != 0);
        chk("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
        if (!rst) chk("req_addr", imem_req_addr_o, m_fpc);
        chk("id_valid", 32'(id_valid_o), 32'(exp_iv));
        chk("count", 32'(count_o), rst ? 32'd0 : 32'(fifoq.size()));
        chk("id_pc", id_pc_o, exp_iv ? fifoq[0].pc : 32'h0);
        chk("id_instr", id_instr_o, exp_iv ? fifoq[0].instr : 32'h0);
        if (imem_req_valid_o && rdy) dut_hs.push_back(imem_req_addr_o);
        if (id_valid_o && idr && !redir) dut_pops.push_back(id_pc_o);
        fire = exp_rv && rdy;
        if (rst) begin
            memq.delete(); outq.delete(); fifoq.delete();
            m_fpc = RST_PC;
        end else begin
            if (resp) begin
                o = outq.pop_front();
                void'(memq.pop_front());
            end
            if (redir) begin
                fifoq.delete();
                foreach (outq[i]) outq[i].keep = 1'b0;
                m_fpc = {rpc[31:2], 2'b00};
            end else begin
                if (idr && fifoq.size() != 0) void'(fifoq.pop_front());
                if (resp && o.keep) fifoq.push_back('{rdata, o.addr});
                if (fire) begin
                    outq.push_back('{m_fpc, 1'b1});
                    memq.push_back('{m_fpc, cyc + int'($urandom_range(lat_max, lat_min))});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b0; imem_resp_data_i = '0;
        id_ready_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then free-run across the 32-bit address wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
        dut_hs.delete(); dut_pops.delete();
        run(8);
        chkq("wrap_hs0", dut_hs, 0, 32'hFFFF_FFF8);
        chkq("wrap_hs1", dut_hs, 1, 32'hFFFF_FFFC);
        chkq("wrap_hs2", dut_hs, 2, 32'h0000_0000);
        chkq("wrap_hs3", dut_hs, 3, 32'h0000_0004);
        chkq("wrap_pop0", dut_pops, 0, 32'hFFFF_FFF8);
        chkq("wrap_pop2", dut_pops, 2, 32'h0000_0000);

        // Decode stall fills the FIFO and stops issue; release drains in order.
        cycle(1'b0, 1'b1, 32'h0);
        idr_pct = 0;
        dut_hs.delete(); dut_pops.delete();
        run(10);
        chk("stall_count", 32'(count_o), 32'd4);
        chk("stall_reqv", 32'(imem_req_valid_o), 32'd0);
        chk("stall_nhs", 32'(dut_hs.size()), 32'd4);
        idr_pct = 100;
        run(8);
        chkq("drain_pop0", dut_pops, 0, 32'h0);
        chkq("drain_pop1", dut_pops, 1, 32'h4);
        chkq("drain_pop2", dut_pops, 2, 32'h8);
        chkq("drain_pop3", dut_pops, 3, 32'hC);
        chkq("resume_hs", dut_hs, 4, 32'h10);

        // 3-cycle memory, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b1, 32'h300);
        run(2);
        cycle(1'b0, 1'b1, 32'h100);
        dut_hs.delete(); dut_pops.delete();
        run(12);
        chkq("lat3_hs0", dut_hs, 0, 32'h100);
        chkq("lat3_pop0", dut_pops, 0, 32'h100);

        // Redirect coinciding with a response, unaligned target.
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b1, 32'h0);
        run(4);
        cycle(1'b0, 1'b1, 32'h203);
        chk("redir_count", 32'(count_o), 32'd0);
        dut_hs.delete();
        run(3);
        chkq("redir_hs0", dut_hs, 0, 32'h200);

        // Reset with the FIFO holding entries and requests outstanding.
        lat_min = 2; lat_max = 2; idr_pct = 0;
        cycle(1'b0, 1'b1, 32'h40);
        run(4);
        chk("pre_rst_count", 32'(count_o), 32'd2);
        cycle(1'b1, 1'b0, 32'h0);
        idr_pct = 100;
        dut_hs.delete();
        run(4);
        chkq("post_rst_hs0", dut_hs, 0, RST_PC);

        // Randomized traffic against the reference model.
        rdy_pct = 70; idr_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(199));
            cycle(r == 0, (r >= 1) && (r <= 10), $urandom());
        end
        lat_max = 1;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
